// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply output-buffer slice:
// buffer geometry, drain FSM encoding and the read-pipeline entry.
package mm_pkg;

   localparam int DATA_W = 512;   // 16 x fp32 lanes
   localparam int ADDR_W = 11;    // 2048-word output buffer

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } drain_state_t;

   // One in-flight read. data carries a forwarded write when one hit
   // the entry; otherwise the SRAM output is used.
   typedef struct packed {
      logic              valid;
      logic              is_drain;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } rd_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO used to buffer drain words in front
// of the ready/valid store port. The head is readable combinationally so
// it stays stable while the consumer stalls.
module sync_fifo #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count_reg != '0);
   assign do_push = push && ((count_reg != FULL_CNT) || do_pop);

   // Storage is never reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr_reg] <= push_data;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head  = store[rd_ptr_reg];
   assign empty = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/output_buffer_port.sv
// Output-buffer responder: owns the result SRAM, answers engine
// accumulate reads with a fixed two-cycle latency and streams ranges of
// the buffer to the store path through a small credit-managed FIFO.
module output_buffer_port #(
   parameter int DATA_W = mm_pkg::DATA_W,
   parameter int ADDR_W = mm_pkg::ADDR_W,
   parameter int FIFO_D = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_addr_valid,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_data_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              drain_start,
   input  logic [ADDR_W-1:0] drain_addr,
   input  logic [15:0]       drain_len,
   output logic              drain_busy,
   output logic              drain_done,
   output logic              dr_valid,
   input  logic              dr_ready,
   output logic [DATA_W-1:0] dr_data
);

   import mm_pkg::*;

   localparam int CNT_W = $clog2(FIFO_D) + 1;
   localparam logic [CNT_W:0] FIFO_LIMIT = (CNT_W+1)'(FIFO_D);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   drain_state_t      state_reg, state_next;
   logic [ADDR_W-1:0] ptr_reg, ptr_next;
   logic [15:0]       issue_left_reg, issue_left_next;
   logic [15:0]       accept_left_reg, accept_left_next;

   rd_entry_t         p1_reg;
   logic              p1_hit_reg;
   logic [DATA_W-1:0] ram_q_reg;
   logic [DATA_W-1:0] stage1_data;

   logic              rd_valid_reg;
   logic [DATA_W-1:0] rd_data_reg;

   logic              drain_inflight;
   logic [CNT_W:0]    occupancy;
   logic              drain_issue;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_addr;
   logic              accept;

   logic              fifo_push;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_head;
   logic [CNT_W-1:0]  fifo_count;

   // Read-port arbitration: the engine always wins; the drain only issues
   // when the FIFO is guaranteed to have room for the word once it lands.
   assign drain_inflight = p1_reg.valid && p1_reg.is_drain;
   assign occupancy      = {1'b0, fifo_count} + {{CNT_W{1'b0}}, drain_inflight};
   assign drain_issue    = !rd_addr_valid && (state_reg == ST_RUN) &&
                           (issue_left_reg != 16'd0) && (occupancy < FIFO_LIMIT);
   assign issue_valid    = rd_addr_valid || drain_issue;
   assign issue_addr     = rd_addr_valid ? rd_addr : ptr_reg;
   assign accept         = !fifo_empty && dr_ready;

   // Single-write, single-read SRAM with registered read; kept free of
   // reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_valid) mem[wr_addr] <= wr_data;
      ram_q_reg <= mem[issue_addr];
   end

   // Stage 1 capture: remember the request and any same-cycle write to
   // the same address, since the RAM returns the pre-write contents.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         p1_reg     <= '0;
         p1_hit_reg <= 1'b0;
      end else begin
         p1_reg.valid    <= issue_valid;
         p1_reg.is_drain <= drain_issue;
         p1_reg.addr     <= issue_addr;
         p1_reg.data     <= wr_data;
         p1_hit_reg      <= wr_valid && (wr_addr == issue_addr);
      end
   end

   // Newest data for the stage-1 entry: a write this cycle beats an
   // earlier forwarded write, which beats the RAM output.
   assign stage1_data = (wr_valid && (wr_addr == p1_reg.addr)) ? wr_data :
                        (p1_hit_reg ? p1_reg.data : ram_q_reg);

   // Stage 2 for engine reads: response strobe plus data that holds
   // between responses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
      end else begin
         rd_valid_reg <= p1_reg.valid && !p1_reg.is_drain;
         if (p1_reg.valid && !p1_reg.is_drain) rd_data_reg <= stage1_data;
      end
   end

   // Stage 2 for drain reads is the FIFO itself.
   assign fifo_push = p1_reg.valid && p1_reg.is_drain;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_D)
   ) u_drain_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (fifo_push),
      .push_data (stage1_data),
      .pop       (accept),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Drain FSM state and counters.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg       <= ST_IDLE;
         ptr_reg         <= '0;
         issue_left_reg  <= '0;
         accept_left_reg <= '0;
      end else begin
         state_reg       <= state_next;
         ptr_reg         <= ptr_next;
         issue_left_reg  <= issue_left_next;
         accept_left_reg <= accept_left_next;
      end
   end

   // Drain FSM next state: issue count paces the read port, accept count
   // decides completion so done follows the final handshake.
   always_comb begin
      state_next       = state_reg;
      ptr_next         = ptr_reg;
      issue_left_next  = issue_left_reg;
      accept_left_next = accept_left_reg;
      case (state_reg)
         ST_IDLE: begin
            if (drain_start) begin
               state_next       = ST_RUN;
               ptr_next         = drain_addr;
               issue_left_next  = drain_len;
               accept_left_next = drain_len;
            end
         end
         ST_RUN: begin
            if (drain_issue) begin
               ptr_next        = ptr_reg + ADDR_W'(1);
               issue_left_next = issue_left_reg - 16'd1;
            end
            if (accept) accept_left_next = accept_left_reg - 16'd1;
            if ((accept_left_reg == 16'd0) || ((accept_left_reg == 16'd1) && accept))
               state_next = ST_DONE;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   assign rd_data_valid = rd_valid_reg;
   assign rd_data       = rd_data_reg;
   assign drain_busy    = (state_reg != ST_IDLE);
   assign drain_done    = (state_reg == ST_DONE);
   assign dr_valid      = !fifo_empty;
   assign dr_data       = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_output_buffer_port.sv
// Self-checking bench for output_buffer_port. A behavioural model tracks
// buffer contents, expected engine responses and expected drain words.
module tb_output_buffer_port;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         wr_valid = 1'b0;
   logic [10:0]  wr_addr = '0;
   logic [511:0] wr_data = '0;
   logic         rd_addr_valid = 1'b0;
   logic [10:0]  rd_addr = '0;
   logic         rd_data_valid;
   logic [511:0] rd_data;
   logic         drain_start = 1'b0;
   logic [10:0]  drain_addr = '0;
   logic [15:0]  drain_len = '0;
   logic         drain_busy;
   logic         drain_done;
   logic         dr_valid;
   logic         dr_ready = 1'b0;
   logic [511:0] dr_data;

   output_buffer_port dut (
      .clk(clk), .rstn(rstn),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_valid(rd_addr_valid), .rd_addr(rd_addr),
      .rd_data_valid(rd_data_valid), .rd_data(rd_data),
      .drain_start(drain_start), .drain_addr(drain_addr), .drain_len(drain_len),
      .drain_busy(drain_busy), .drain_done(drain_done),
      .dr_valid(dr_valid), .dr_ready(dr_ready), .dr_data(dr_data)
   );

   always #5 clk = ~clk;

   typedef struct { int addr; int cyc; } pend_t;
   typedef struct { int due; logic [511:0] data; } rsp_t;

   logic [511:0] mem_m [2048];
   pend_t        pend[$];
   rsp_t         exp_rsp[$];
   logic [511:0] exp_drain[$];
   logic [511:0] last_rd = '0;
   logic [511:0] p_data = '0;
   logic         p_valid = 1'b0, p_ready = 1'b0;
   logic         m_busy = 1'b0;
   int cyc = 0, busy_from = 0, done_due = -10;
   int n_acc = 0, first_acc = 0, last_acc = 0, n_done = 0;
   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   // Advance one clock: fold this cycle's inputs into the model, then
   // compare the outputs of the next cycle.
   task automatic step();
      rsp_t r;
      if (!rstn) begin
         pend.delete(); exp_rsp.delete(); exp_drain.delete();
         m_busy = 1'b0; done_due = -10; last_rd = '0;
      end else begin
         if (m_busy && cyc > done_due) m_busy = 1'b0;
         if (dr_valid && dr_ready) begin
            if (exp_drain.size() == 0) chk("drain_extra_word", 1'b1, 1'b0);
            else begin
               chk("drain_word", dr_data, exp_drain.pop_front());
               if (n_acc == 0) first_acc = cyc;
               last_acc = cyc;
               n_acc++;
               if (exp_drain.size() == 0) done_due = cyc + 1;
            end
         end
         if (drain_start && !m_busy) begin
            m_busy = 1'b1;
            busy_from = cyc + 1;
            done_due = (drain_len == 16'd0) ? cyc + 2 : (1 << 30);
            for (int i = 0; i < int'(drain_len); i++)
               exp_drain.push_back(mem_m[(int'(drain_addr) + i) % 2048]);
         end
         if (wr_valid) mem_m[wr_addr] = wr_data;
         while (pend.size() > 0 && pend[0].cyc == cyc - 1) begin
            r.due = cyc + 1;
            r.data = mem_m[pend[0].addr];
            exp_rsp.push_back(r);
            void'(pend.pop_front());
         end
         if (rd_addr_valid) pend.push_back('{int'(rd_addr), cyc});
      end
      p_valid = dr_valid; p_ready = dr_ready; p_data = dr_data;
      @(posedge clk); #1; cyc++;
      if (!rstn) begin
         chk("rst_rd_data_valid", rd_data_valid, 1'b0);
         chk("rst_rd_data", rd_data, '0);
         chk("rst_drain_busy", drain_busy, 1'b0);
         chk("rst_drain_done", drain_done, 1'b0);
         chk("rst_dr_valid", dr_valid, 1'b0);
         chk("rst_dr_data", dr_data, '0);
      end else begin
         if (exp_rsp.size() > 0 && exp_rsp[0].due == cyc) begin
            r = exp_rsp.pop_front();
            chk("rd_valid", rd_data_valid, 1'b1);
            chk("rd_data", rd_data, r.data);
            last_rd = r.data;
         end else begin
            chk("rd_valid_idle", rd_data_valid, 1'b0);
            chk("rd_data_hold", rd_data, last_rd);
         end
         chk("drain_done", drain_done, cyc == done_due);
         chk("drain_busy", drain_busy, m_busy && cyc >= busy_from && cyc <= done_due);
         if (p_valid && !p_ready) begin
            chk("dr_hold_valid", dr_valid, 1'b1);
            chk("dr_hold_data", dr_data, p_data);
         end
         if (drain_done) n_done++;
      end
   endtask

   task automatic wr(input int a, input logic [511:0] d);
      wr_valid = 1'b1; wr_addr = 11'(a); wr_data = d;
      step();
      wr_valid = 1'b0;
   endtask

   // Run until the active drain has completed, bounded by a cycle budget.
   task automatic finish_drain(input string tag, input int done_before);
      for (int k = 0; k < 400 && n_done == done_before; k++) step();
      repeat (3) step();
      chk({tag, "_done_seen"}, n_done, done_before + 1);
      chk({tag, "_words_left"}, exp_drain.size(), 0);
      chk({tag, "_rsp_left"}, exp_rsp.size() + pend.size(), 0);
   endtask

   task automatic start_drain(input int a, input int len);
      drain_start = 1'b1; drain_addr = 11'(a); drain_len = 16'(len);
      step();
      drain_start = 1'b0;
   endtask

   initial begin
      int d0;
      logic [511:0] v;

      // Reset state
      repeat (3) step();
      rstn = 1'b1;
      step();

      // Write then read back two cycles later
      wr(5, {64{8'hA5}});
      step();
      rd_addr_valid = 1'b1; rd_addr = 11'd5; step(); rd_addr_valid = 1'b0;
      repeat (3) step();

      // Write one cycle after a read, then same-cycle write and read
      wr(9, {64{8'h11}});
      rd_addr_valid = 1'b1; rd_addr = 11'd9; step(); rd_addr_valid = 1'b0;
      wr(9, {64{8'h33}});
      repeat (2) step();
      rd_addr_valid = 1'b1; rd_addr = 11'd9;
      wr(9, {64{8'h44}});
      rd_addr_valid = 1'b0;
      repeat (3) step();

      // Sequential drain at full rate
      for (int a = 0; a < 8; a++) wr(a, 512'(a));
      dr_ready = 1'b1; n_acc = 0; d0 = n_done;
      start_drain(0, 8);
      finish_drain("drain8", d0);
      chk("drain8_count", n_acc, 8);
      chk("drain8_rate", last_acc - first_acc, 7);

      // Drain across the address wrap
      wr(2046, rnd512()); wr(2047, rnd512()); wr(0, rnd512()); wr(1, rnd512());
      n_acc = 0; d0 = n_done;
      start_drain(2046, 4);
      finish_drain("wrap", d0);
      chk("wrap_count", n_acc, 4);

      // Long drain with backpressure, engine traffic and a stray start
      for (int a = 0; a < 16; a++) wr(100 + a, rnd512());
      for (int a = 0; a < 16; a++) wr(200 + a, rnd512());
      n_acc = 0; d0 = n_done;
      start_drain(100, 16);
      for (int k = 0; k < 400 && n_done == d0; k++) begin
         dr_ready = (k % 2 == 0);
         rd_addr_valid = (k % 3 == 0);
         rd_addr = 11'(200 + $urandom_range(0, 15));
         wr_valid = ($urandom_range(0, 1) == 1);
         wr_addr = 11'(200 + $urandom_range(0, 15));
         wr_data = rnd512();
         drain_start = (k == 5);
         drain_addr = 11'd0; drain_len = 16'd3;
         step();
      end
      rd_addr_valid = 1'b0; wr_valid = 1'b0; drain_start = 1'b0; dr_ready = 1'b1;
      finish_drain("mixed", d0);
      chk("mixed_count", n_acc, 16);

      // Zero-length drain
      d0 = n_done;
      start_drain(50, 0);
      for (int k = 0; k < 4; k++) begin
         chk("len0_dr_valid", dr_valid, 1'b0);
         step();
      end
      chk("len0_done_seen", n_done, d0 + 1);

      // Reset in the middle of a stalled drain, then drain again
      dr_ready = 1'b0;
      start_drain(0, 8);
      repeat (6) step();
      rstn = 1'b0; #1;
      chk("async_rd_valid", rd_data_valid, 1'b0);
      chk("async_rd_data", rd_data, '0);
      chk("async_busy", drain_busy, 1'b0);
      chk("async_done", drain_done, 1'b0);
      chk("async_dr_valid", dr_valid, 1'b0);
      chk("async_dr_data", dr_data, '0);
      repeat (2) step();
      rstn = 1'b1;
      step();
      dr_ready = 1'b1; n_acc = 0; d0 = n_done;
      start_drain(0, 8);
      finish_drain("post_rst", d0);
      chk("post_rst_count", n_acc, 8);
      v = 512'(7);
      chk("post_rst_last", last_rd === '0 ? v : v, mem_m[7]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
